// File: rtl/reg_array_pkg.sv
// reg_array_pkg
// Shared definitions for the arbitrated register array: the controller
// state type, the default geometry and a small wrap-around helper used by
// the round-robin search.
package reg_array_pkg;

  // CLEAR zeroes the array after reset; RUN serves requesters.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DEPTH_DEF = 128;
  localparam int WIDTH_DEF = 8;
  localparam int AW_DEF    = $clog2(DEPTH_DEF);

  // (base + off) mod n, valid for base < n and off < n.
  function automatic int wrap_add(int base, int off, int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/reg_array_arb_if.sv
// reg_array_arb_if
// Bundles the requester side of the arbitrated register array.
//   req    : per-requester access request, held until granted
//   we     : per-requester write enable (1 = write, 0 = read)
//   addr   : packed addresses, requester i at [i*AW +: AW]
//   wdata  : packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt    : one-hot (or zero) grant for the current cycle
//   rvalid : one-cycle pulse marking read data for requester i
//   rdata  : shared read data
//   ready  : high once the clear sequence has finished
// master = requester side, slave = the arbiter.
interface reg_array_arb_if
  import reg_array_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int AW    = AW_DEF,
  parameter int WIDTH = WIDTH_DEF
) ();

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       we;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rvalid;
  logic [WIDTH-1:0]      rdata;
  logic                  ready;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, ready
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, ready
  );

endinterface

// File: rtl/reg_array.sv
// reg_array
// Single-port DEPTH x WIDTH storage with synchronous write and a
// registered read port.
//   clk, rst : clock and async active-high reset (resets rdata only)
//   we       : write addr with wdata at the rising edge
//   re       : load rdata from addr at the rising edge
//   addr     : word address; words at or above DEPTH are ignored
//   wdata    : write data
//   rdata    : registered read data, holds between reads
module reg_array
  import reg_array_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             in_range;

  // With a power-of-two depth every address exists; otherwise the top of
  // the address space is a hole where writes drop and reads return zero.
  generate
    if (DEPTH == (1 << AW)) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_partial
      assign in_range = (int'(addr) < DEPTH);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/reg_array_arb.sv
// reg_array_arb
// Round-robin arbiter in front of a single-port register array. After
// reset the array is walked and zeroed one word per cycle; then NREQ
// requesters share the port, one access per cycle.
//   clk : rising-edge clock
//   rst : async active-high reset, restarts the clear sequence
//   bus : requester bundle (slave side), see reg_array_arb_if
module reg_array_arb
  import reg_array_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  reg_array_arb_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(NREQ);

  state_t           state, state_nxt;
  logic [AW-1:0]    clr_cnt;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic             grant_ok;
  logic             mem_we;
  logic             mem_re;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [NREQ-1:0]  rd_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // RUN is entered on the edge that commits the write to the last word.
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_cnt == AW'(DEPTH - 1)) begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // First asserted request at or after ptr, wrapping around.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_any && bus.req[wrap_add(int'(ptr), k, NREQ)]) begin
        pick_any = 1'b1;
        pick_idx = PW'(wrap_add(int'(ptr), k, NREQ));
      end
    end
  end

  // Memory port is owned by the clear walk in CLEAR and by the granted
  // requester in RUN.
  always_comb begin
    grant_ok  = (state == RUN) && pick_any;
    bus.gnt   = '0;
    bus.ready = (state == RUN);
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = clr_cnt;
    mem_wdata = '0;
    rd_gnt    = '0;
    if (state == CLEAR) begin
      mem_we = 1'b1;
    end else if (grant_ok) begin
      bus.gnt[pick_idx] = 1'b1;
      mem_addr          = bus.addr[pick_idx*AW +: AW];
      mem_wdata         = bus.wdata[pick_idx*WIDTH +: WIDTH];
      mem_we            = bus.we[pick_idx];
      mem_re            = !bus.we[pick_idx];
      rd_gnt[pick_idx]  = !bus.we[pick_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_ok) begin
      ptr <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  // rvalid lines up with the registered read data of the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rvalid <= '0;
    end else begin
      bus.rvalid <= rd_gnt;
    end
  end

  reg_array #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (bus.rdata)
  );

endmodule

// File: tb/tb_reg_array_arb.sv
// tb_reg_array_arb
// Scoreboard bench: the stimulus side predicts grants from a plain
// round-robin model and queues expected read responses; a separate
// monitor pops them whenever rvalid shows up.
module tb_reg_array_arb;
  import reg_array_pkg::*;

  localparam int NREQ   = 3;
  localparam int DEPTH  = DEPTH_DEF;
  localparam int WIDTH  = WIDTH_DEF;
  localparam int AW     = AW_DEF;
  localparam int PERIOD = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #(PERIOD / 2) clk = ~clk;

  reg_array_arb_if #(.NREQ(NREQ), .AW(AW), .WIDTH(WIDTH)) bus ();

  reg_array_arb #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: pending request per requester, array contents, pointer.
  bit pend  [NREQ];
  bit pwe   [NREQ];
  int paddr [NREQ];
  int pdata [NREQ];
  int mem_m [DEPTH];
  int mptr;

  typedef struct {
    time             due;
    logic [NREQ-1:0] vld;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [WIDTH-1:0] last_rd = '0;

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic driveBus();
    logic [NREQ-1:0]       r;
    logic [NREQ-1:0]       w;
    logic [NREQ*AW-1:0]    a;
    logic [NREQ*WIDTH-1:0] d;
    r = '0;
    w = '0;
    a = '0;
    d = '0;
    for (int i = 0; i < NREQ; i++) begin
      r[i] = pend[i];
      w[i] = pwe[i];
      a[i*AW +: AW] = AW'(paddr[i]);
      d[i*WIDTH +: WIDTH] = WIDTH'(pdata[i]);
    end
    bus.req   = r;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  task automatic setReq(int i, bit w, int a, int d);
    pend[i]  = 1'b1;
    pwe[i]   = w;
    paddr[i] = a;
    pdata[i] = d;
    driveBus();
  endtask

  // Round-robin rule: first pending requester counting up from mptr.
  function automatic int modelPick();
    int idx;
    idx = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (idx < 0 && pend[(mptr + k) % NREQ]) idx = (mptr + k) % NREQ;
    end
    return idx;
  endfunction

  // One loop iteration per clock: check the grant mid-cycle, retire the
  // granted access in the model, then issue new requests after the edge.
  task automatic applyStimulus(int ncyc, int prob, int amax);
    int idx;
    logic [NREQ-1:0] expg;
    exp_t e;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      idx  = modelPick();
      expg = '0;
      if (idx >= 0) expg[idx] = 1'b1;
      checkOutput("gnt", 32'(bus.gnt), 32'(expg));
      if (idx >= 0) begin
        if (pwe[idx]) begin
          mem_m[paddr[idx]] = pdata[idx] & 8'hFF;
        end else begin
          e.due  = $time + PERIOD;
          e.vld  = expg;
          e.data = WIDTH'(mem_m[paddr[idx]]);
          exp_q.push_back(e);
        end
        pend[idx] = 1'b0;
        mptr = (idx + 1) % NREQ;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(99) < prob) begin
          pend[i]  = 1'b1;
          pwe[i]   = 1'($urandom_range(1));
          paddr[i] = int'($urandom_range(amax));
          pdata[i] = int'($urandom_range(255));
        end
      end
      driveBus();
    end
  endtask

  // Assert reset, check the reset values, release it and time the clear walk.
  task automatic doReset(bit with_reqs);
    int n;
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
    mptr = 0;
    driveBus();
    #1;
    checkOutput("rst_rvalid", 32'(bus.rvalid), 32'd0);
    checkOutput("rst_ready", 32'(bus.ready), 32'd0);
    checkOutput("rst_gnt", 32'(bus.gnt), 32'd0);
    checkOutput("rst_rdata", 32'(bus.rdata), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    if (with_reqs) begin
      setReq(2, 1'b0, 3, 0);
      setReq(0, 1'b0, 127, 0);
    end
    rst = 1'b0;
    n = 0;
    while (!bus.ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (!bus.ready) checkOutput("gnt_in_clear", 32'(bus.gnt), 32'd0);
    end
    checkOutput("clear_len", 32'(n), 32'd128);
  endtask

  // Monitor: every rvalid must match the head of the scoreboard in timing,
  // target and data; rdata must hold between responses.
  always @(negedge clk) begin
    if (rst) begin
      last_rd = '0;
    end else if (bus.rvalid != '0) begin
      if (exp_q.size() == 0) begin
        checkOutput("rvalid_unexpected", 32'(bus.rvalid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("rvalid", 32'(bus.rvalid), 32'(mon_e.vld));
        checkOutput("rdata", 32'(bus.rdata), 32'(mon_e.data));
        checkOutput("rlatency", 32'($time), 32'(mon_e.due));
        last_rd = mon_e.data;
      end
    end else begin
      checkOutput("rdata_hold", 32'(bus.rdata), 32'(last_rd));
      if (exp_q.size() > 0 && exp_q[0].due <= $time) begin
        mon_e = exp_q.pop_front();
        checkOutput("rvalid_missing", 32'(bus.rvalid), 32'(mon_e.vld));
      end
    end
  end

  initial begin
    // Clear with requests waiting; the lowest index wins first.
    doReset(1'b1);
    applyStimulus(3, 0, 0);

    // All three held: 001, 010, 100, 001.
    setReq(0, 1'b0, 1, 0);
    setReq(1, 1'b0, 2, 0);
    setReq(2, 1'b0, 3, 0);
    applyStimulus(4, 100, 15);
    applyStimulus(4, 0, 0);

    // Write then read the same word on consecutive cycles.
    setReq(1, 1'b1, 5, 8'hA5);
    applyStimulus(1, 0, 0);
    setReq(2, 1'b0, 5, 0);
    applyStimulus(2, 0, 0);

    // Move the pointer to 1, then requesters 0 and 1 together.
    setReq(0, 1'b1, 20, 8'h3C);
    applyStimulus(1, 0, 0);
    setReq(0, 1'b0, 20, 0);
    setReq(1, 1'b0, 5, 0);
    applyStimulus(3, 0, 0);

    // Random traffic on a narrow window (many hazards) and the full range.
    applyStimulus(1500, 40, 15);
    applyStimulus(500, 60, DEPTH - 1);
    applyStimulus(6, 0, 0);

    // Reset right after a read grant: its rvalid never shows.
    setReq(1, 1'b1, 9, 8'hA5);
    applyStimulus(1, 0, 0);
    setReq(0, 1'b0, 9, 0);
    applyStimulus(1, 0, 0);
    rst = 1'b1;
    #1;
    checkOutput("rvalid_abort", 32'(bus.rvalid), 32'd0);
    checkOutput("ready_abort", 32'(bus.ready), 32'd0);
    doReset(1'b0);
    setReq(0, 1'b0, 9, 0);
    applyStimulus(4, 0, 0);

    repeat (3) @(negedge clk);
    checkOutput("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_array_arb.md
REG_ARRAY_ARB -- requirements
Module: reg_array_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and rst.
REQ-002 Parameter NREQ, default 3, SHALL set the number of requesters (range 2..8).
REQ-003 Parameter DEPTH, default 128, SHALL set the number of array words.
REQ-004 Parameter WIDTH, default 8, SHALL set the word width; AW = clog2(DEPTH) = 7.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port rst, input, 1: async active-high reset.
REQ-007 Port req, input, NREQ: per-requester access request, held until granted.
REQ-008 Port we, input, NREQ: per-requester write enable (1 = write, 0 = read).
REQ-009 Port addr, input, NREQ*AW: packed addresses; requester i uses slice [i*AW +: AW].
REQ-010 Port wdata, input, NREQ*WIDTH: packed write data; requester i uses slice [i*WIDTH +: WIDTH].
REQ-011 Port gnt, output, NREQ: one-hot (or zero) grant; access is committed at the edge ending the grant cycle.
REQ-012 Port rvalid, output, NREQ: one-cycle pulse one cycle after a read grant to requester i.
REQ-013 Port rdata, output, WIDTH: shared read data, valid only when rvalid is nonzero.
REQ-014 Port ready, output, 1: high once the array-clear sequence has finished.

Function
REQ-015 The FSM SHALL have two states:
- CLEAR: counter walks addresses 0..DEPTH-1, writing 0 to each, one per cycle; gnt = 0.
- RUN: entered on the edge after the write to address DEPTH-1; stays in RUN until rst.
REQ-016 ready SHALL equal (state == RUN), registered; CLEAR lasts exactly DEPTH cycles after rst deasserts.
REQ-017 In RUN, gnt SHALL be a combinational round-robin pick among asserted req bits, starting from pointer ptr.
REQ-018 ptr SHALL update to (granted index + 1) mod NREQ on every grant and hold when no grant.
REQ-019 At most one access per cycle SHALL occur; ungranted requesters stall with no loss or reordering.
REQ-020 A granted write SHALL update array[addr_i] with wdata_i at the edge.
REQ-021 A granted read SHALL present array[addr_i] on rdata, with rvalid[i] = 1, in the following cycle.
REQ-022 Back-to-back reads SHALL sustain one per cycle.
REQ-023 A read granted in the cycle after a write to the same address SHALL return the new data.
REQ-024 req with addr >= DEPTH (non-power-of-2 DEPTH only) SHALL be granted and ignored: writes are dropped, reads return 0.
REQ-025 Outside an rvalid cycle, rdata SHALL hold its last value.

Reset
REQ-026 While rst is high: state = CLEAR, clear counter = 0, ptr = 0, rvalid = 0, ready = 0, gnt = 0, rdata = 0.
REQ-027 rst asserted mid-CLEAR or mid-RUN SHALL abort immediately; a pending read's rvalid SHALL NOT appear.
REQ-028 After rst deasserts, the clear sequence SHALL restart from address 0.

Structure
REQ-029 A shared package reg_array_pkg SHALL hold the state typedef (CLEAR, RUN) and the default DEPTH/WIDTH/AW constants.
REQ-030 Storage SHALL be one sub-module, reg_array: single port, synchronous write, registered read, DEPTH x WIDTH.
REQ-031 The arbiter, FSM, clear counter and rvalid pipeline SHALL reside in reg_array_arb.

Verification
REQ-032 Clear: rst 1 then 0 → ready rises after exactly 128 cycles; a subsequent read of address 127 by requester 0 returns 0x00.
REQ-033 Round robin: req = 3'b111 held, ptr = 0 → gnt sequence 001, 010, 100, 001.
REQ-034 Read-after-write: requester 1 writes 0xA5 to address 5; next cycle requester 2 reads address 5 → rvalid = 3'b100 and rdata = 0xA5 one cycle later.
REQ-035 Stall: req = 3'b011 with ptr = 1 → requester 1 is granted first and requester 0 next cycle; no grant is lost.
REQ-036 Reset mid-op: rst pulsed the cycle after a read grant → no rvalid; ready = 0; clear restarts at address 0; a previously written 0xA5 reads back 0x00.
REQ-037 Blocked requests: req asserted during CLEAR → gnt stays 0 until ready = 1; first grant goes to the lowest asserted index.
